// File: rtl/result_drain_pkg.sv
// Shared defaults, index-width helper and reader state encoding for the result drain.
package result_drain_pkg;

  localparam int unsigned N_DEF      = 4;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned CASE_W_DEF = 8;

  // A 1x1 array still needs a 1-bit index port.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n * n > 1) ? $clog2(n * n) : 1;
  endfunction

  localparam int unsigned IDX_W = idx_w(N_DEF);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/result_buf.sv
// Two-entry ping-pong store for full PE result frames plus case tags and occupancy flags.
module result_buf
  import result_drain_pkg::*;
#(
  parameter int unsigned N      = N_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CASE_W = CASE_W_DEF,
  parameter int unsigned IW     = idx_w(N_DEF)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  wr_sel,
  input  logic [N*N*DATA_W-1:0] wr_data,
  input  logic [CASE_W-1:0]     wr_tag,
  input  logic                  rel_en,
  input  logic                  rel_sel,
  input  logic                  rd_sel,
  input  logic [IW-1:0]         rd_idx,
  output logic [DATA_W-1:0]     rd_data,
  output logic [CASE_W-1:0]     rd_tag,
  output logic [1:0]            occ
);

  localparam int unsigned NE = N * N;

  logic [DATA_W-1:0] mem_q [2][NE];
  logic [CASE_W-1:0] tag_q [2];
  logic [1:0]        occ_q;
  logic [1:0]        occ_d;

  // Write wins over release so a slot reused in its release cycle stays occupied.
  always_comb begin
    occ_d = occ_q;
    if (rel_en) occ_d[rel_sel] = 1'b0;
    if (wr_en)  occ_d[wr_sel]  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) occ_q <= 2'b00;
    else     occ_q <= occ_d;
  end

  // Payload storage is not reset; the occupancy flags qualify it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_sel] <= wr_tag;
      for (int k = 0; k < int'(NE); k++) begin
        mem_q[wr_sel][k] <= wr_data[k*DATA_W +: DATA_W];
      end
    end
  end

  assign rd_data = mem_q[rd_sel][rd_idx];
  assign rd_tag  = tag_q[rd_sel];
  assign occ     = occ_q;

endmodule

// File: rtl/result_drain.sv
// Captures final PE array results into a ping-pong buffer and streams them out
// one element per valid/ready transfer, tagged with a running case number.
module result_drain
  import result_drain_pkg::*;
#(
  parameter int unsigned N      = N_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CASE_W = CASE_W_DEF
) (
  input  logic                      clk,
  input  logic                      rstSys,
  input  logic                      start_check,
  input  logic [N*N*DATA_W-1:0]     psumArr,
  output logic                      outValid,
  input  logic                      outReady,
  output logic [DATA_W-1:0]         outData,
  output logic [idx_w(N)-1:0]       outIdx,
  output logic                      outLast,
  output logic [CASE_W-1:0]         outCase,
  output logic                      overflow,
  output logic                      busy
);

  localparam int unsigned IW = idx_w(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N * N - 1);

  state_t            state_q;
  state_t            state_d;
  logic              rd_ptr_q;
  logic              wr_ptr_q;
  logic [IW-1:0]     idx_q;
  logic [CASE_W-1:0] case_q;
  logic              overflow_q;

  logic [1:0]        occ;
  logic [DATA_W-1:0] rd_data;
  logic [CASE_W-1:0] rd_tag;
  logic              at_last;
  logic              xfer;
  logic              rel;
  logic              slot_free;
  logic              capture;
  logic              drop;
  logic              other_next;

  assign at_last   = (idx_q == LAST_IDX);
  assign xfer      = (state_q == DRAIN) && outReady;
  assign rel       = xfer && at_last;
  // A slot emptied by this cycle's final transfer may be refilled on the same edge.
  assign slot_free = !occ[wr_ptr_q] || (rel && (rd_ptr_q == wr_ptr_q));
  assign capture   = start_check && !rstSys && slot_free;
  assign drop      = start_check && !rstSys && !slot_free;
  // Whether the slot after the current read slot holds a case once this edge completes.
  assign other_next = occ[~rd_ptr_q] || (capture && (wr_ptr_q != rd_ptr_q));

  result_buf #(
    .N      (N),
    .DATA_W (DATA_W),
    .CASE_W (CASE_W),
    .IW     (IW)
  ) u_buf (
    .clk     (clk),
    .rst     (rstSys),
    .wr_en   (capture),
    .wr_sel  (wr_ptr_q),
    .wr_data (psumArr),
    .wr_tag  (case_q),
    .rel_en  (rel),
    .rel_sel (rd_ptr_q),
    .rd_sel  (rd_ptr_q),
    .rd_idx  (idx_q),
    .rd_data (rd_data),
    .rd_tag  (rd_tag),
    .occ     (occ)
  );

  always_ff @(posedge clk) begin
    if (rstSys) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (capture || (occ != 2'b00)) state_d = DRAIN;
      DRAIN:   if (rel && !other_next)        state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    outValid = (state_q == DRAIN);
    outData  = '0;
    outCase  = '0;
    outLast  = 1'b0;
    if (outValid) begin
      outData = rd_data;
      outCase = rd_tag;
      outLast = at_last;
    end
  end

  // Pointers, element index, case counter and sticky overflow.
  always_ff @(posedge clk) begin
    if (rstSys) begin
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      idx_q      <= '0;
      case_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (rel)         rd_ptr_q <= ~rd_ptr_q;
      if (capture)     wr_ptr_q <= ~wr_ptr_q;
      if (xfer)        idx_q    <= at_last ? '0 : idx_q + IW'(1);
      if (start_check) case_q   <= case_q + CASE_W'(1);
      if (drop)        overflow_q <= 1'b1;
    end
  end

  assign outIdx   = idx_q;
  assign overflow = overflow_q;
  assign busy     = |occ;

endmodule

// File: tb/tb_result_drain.sv
// Scoreboard bench for result_drain: expected words are queued at capture time
// and compared as the DUT presents them.
module tb_result_drain;

  localparam int unsigned N      = 4;
  localparam int unsigned NE     = N * N;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CASE_W = 8;
  localparam int unsigned IW     = 4;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [IW-1:0]     idx;
    logic [CASE_W-1:0] cs;
    logic              last;
  } exp_t;

  logic                  clk;
  logic                  rstSys;
  logic                  start_check;
  logic [NE*DATA_W-1:0]  psumArr;
  logic                  outValid;
  logic                  outReady;
  logic [DATA_W-1:0]     outData;
  logic [IW-1:0]         outIdx;
  logic                  outLast;
  logic [CASE_W-1:0]     outCase;
  logic                  overflow;
  logic                  busy;

  int checks   = 0;
  int failures = 0;
  exp_t q[$];
  logic [CASE_W-1:0] exp_case = '0;

  result_drain #(.N(N), .DATA_W(DATA_W), .CASE_W(CASE_W)) dut (
    .clk         (clk),
    .rstSys      (rstSys),
    .start_check (start_check),
    .psumArr     (psumArr),
    .outValid    (outValid),
    .outReady    (outReady),
    .outData     (outData),
    .outIdx      (outIdx),
    .outLast     (outLast),
    .outCase     (outCase),
    .overflow    (overflow),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NE*DATA_W-1:0] mk_ramp(input int base);
    logic [NE*DATA_W-1:0] v;
    for (int k = 0; k < int'(NE); k++) v[k*DATA_W +: DATA_W] = DATA_W'(base + k);
    return v;
  endfunction

  function automatic logic [NE*DATA_W-1:0] mk_rand();
    logic [NE*DATA_W-1:0] v;
    for (int k = 0; k < int'(NE); k++) v[k*DATA_W +: DATA_W] = DATA_W'($urandom);
    return v;
  endfunction

  // Queue one captured case and advance the expected tag.
  task automatic push_case(input logic [NE*DATA_W-1:0] v);
    exp_t e;
    for (int k = 0; k < int'(NE); k++) begin
      e.data = v[k*DATA_W +: DATA_W];
      e.idx  = IW'(k);
      e.cs   = exp_case;
      e.last = (k == int'(NE) - 1);
      q.push_back(e);
    end
    exp_case = exp_case + CASE_W'(1);
  endtask

  task automatic test_reset;
    rstSys = 1'b1; start_check = 1'b1; outReady = 1'b0; psumArr = mk_ramp(7);
    repeat (3) @(negedge clk);
    rstSys = 1'b0; start_check = 1'b0;
    @(negedge clk);
    checks++;
    if ({outValid, outLast, busy, overflow} !== 4'b0000 || outData !== '0 || outCase !== '0 || outIdx !== '0) begin
      failures++;
      $display("FAIL reset: got valid=%b last=%b busy=%b ovf=%b data=%0d case=%0d idx=%0d, want all 0",
               outValid, outLast, busy, overflow, outData, outCase, outIdx);
    end
  endtask

  task automatic test_single;
    exp_t e;
    psumArr = mk_ramp(100); start_check = 1'b1; outReady = 1'b1;
    push_case(psumArr);
    @(negedge clk);
    start_check = 1'b0;
    checks++;
    if (outValid !== 1'b1 || outIdx !== '0) begin
      failures++;
      $display("FAIL single_latency: got valid=%b idx=%0d, want valid=1 idx=0", outValid, outIdx);
    end
    for (int c = 0; c < 40 && q.size() > 0; c++) begin
      if (outValid && outReady) begin
        e = q.pop_front();
        checks++;
        if ({outData, outIdx, outCase, outLast} !== {e.data, e.idx, e.cs, e.last}) begin
          failures++;
          $display("FAIL single_word: got d=%0d i=%0d c=%0d l=%b, want d=%0d i=%0d c=%0d l=%b",
                   outData, outIdx, outCase, outLast, e.data, e.idx, e.cs, e.last);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (q.size() != 0 || outValid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_end: got left=%0d valid=%b busy=%b, want 0 0 0", q.size(), outValid, busy);
    end
  endtask

  task automatic test_backpressure;
    exp_t e;
    logic stall;
    logic [DATA_W+IW+CASE_W-1:0] held;
    stall = 1'b0; held = '0;
    for (int c = 0; c < 100 && (c == 0 || q.size() > 0); c++) begin
      start_check = (c == 0);
      if (c == 0) begin
        psumArr = mk_ramp(200);
        push_case(psumArr);
      end
      outReady = (c % 4 == 0) || (c % 4 == 3);
      if (stall) begin
        checks++;
        if (outValid !== 1'b1 || {outData, outIdx, outCase} !== held) begin
          failures++;
          $display("FAIL bp_stall: got valid=%b word=%h, want valid=1 word=%h", outValid, {outData, outIdx, outCase}, held);
        end
      end
      stall = outValid && !outReady;
      held  = {outData, outIdx, outCase};
      if (outValid && outReady) begin
        e = q.pop_front();
        checks++;
        if ({outData, outIdx, outCase, outLast} !== {e.data, e.idx, e.cs, e.last}) begin
          failures++;
          $display("FAIL bp_word: got d=%0d i=%0d c=%0d l=%b, want d=%0d i=%0d c=%0d l=%b",
                   outData, outIdx, outCase, outLast, e.data, e.idx, e.cs, e.last);
        end
      end
      @(negedge clk);
    end
    start_check = 1'b0;
    checks++;
    if (q.size() != 0 || outValid !== 1'b0) begin
      failures++;
      $display("FAIL bp_end: got left=%0d valid=%b, want 0 0", q.size(), outValid);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int nvalid, first, lastc;
    nvalid = 0; first = -1; lastc = -1;
    outReady = 1'b1;
    for (int c = 0; c < 45; c++) begin
      start_check = (c == 0) || (c == 3);
      if (c == 0) begin psumArr = mk_ramp(300); push_case(psumArr); end
      if (c == 3) begin psumArr = mk_rand();    push_case(psumArr); end
      if (outValid) begin
        nvalid++;
        if (first < 0) first = c;
        lastc = c;
        if (q.size() > 0) begin
          e = q.pop_front();
          checks++;
          if ({outData, outIdx, outCase, outLast} !== {e.data, e.idx, e.cs, e.last}) begin
            failures++;
            $display("FAIL b2b_word: got d=%0d i=%0d c=%0d l=%b, want d=%0d i=%0d c=%0d l=%b",
                     outData, outIdx, outCase, outLast, e.data, e.idx, e.cs, e.last);
          end
        end
      end
      @(negedge clk);
    end
    start_check = 1'b0;
    checks++;
    if (nvalid != 32 || lastc - first + 1 != 32 || first != 1 || q.size() != 0) begin
      failures++;
      $display("FAIL b2b_contig: got valid_cycles=%0d span=%0d first=%0d left=%0d, want 32 32 1 0",
               nvalid, lastc - first + 1, first, q.size());
    end
  endtask

  task automatic test_simultaneous;
    exp_t e;
    logic fired;
    logic [CASE_W-1:0] cx;
    fired = 1'b0;
    cx = exp_case;
    outReady = 1'b0;
    for (int c = 0; c < 4; c++) begin
      start_check = (c == 0) || (c == 2);
      if (c == 0) begin psumArr = mk_ramp(1000); push_case(psumArr); end
      if (c == 2) begin psumArr = mk_ramp(2000); push_case(psumArr); end
      @(negedge clk);
    end
    start_check = 1'b0;
    outReady = 1'b1;
    for (int c = 0; c < 100 && q.size() > 0; c++) begin
      start_check = !fired && outValid && outLast && (outCase == cx);
      if (start_check) begin
        psumArr = mk_ramp(3000);
        push_case(psumArr);
        fired = 1'b1;
      end
      if (outValid) begin
        e = q.pop_front();
        checks++;
        if ({outData, outIdx, outCase, outLast} !== {e.data, e.idx, e.cs, e.last}) begin
          failures++;
          $display("FAIL sim_word: got d=%0d i=%0d c=%0d l=%b, want d=%0d i=%0d c=%0d l=%b",
                   outData, outIdx, outCase, outLast, e.data, e.idx, e.cs, e.last);
        end
      end
      @(negedge clk);
    end
    start_check = 1'b0;
    checks++;
    if (!fired || overflow !== 1'b0 || q.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL sim_end: got fired=%b ovf=%b left=%0d busy=%b, want 1 0 0 0", fired, overflow, q.size(), busy);
    end
  endtask

  task automatic test_overflow;
    exp_t e;
    outReady = 1'b0;
    for (int c = 0; c < 9; c++) begin
      start_check = (c == 0) || (c == 2) || (c == 4);
      if (c == 0) begin psumArr = mk_ramp(600); push_case(psumArr); end
      if (c == 2) begin psumArr = mk_ramp(700); push_case(psumArr); end
      if (c == 4) begin psumArr = mk_ramp(800); exp_case = exp_case + CASE_W'(1); end
      if (c == 4) begin
        checks++;
        if (overflow !== 1'b0) begin
          failures++;
          $display("FAIL ovf_pre: got overflow=%b, want 0", overflow);
        end
      end
      if (c == 5 || c == 8) begin
        checks++;
        if (overflow !== 1'b1 || busy !== 1'b1) begin
          failures++;
          $display("FAIL ovf_set c%0d: got overflow=%b busy=%b, want 1 1", c, overflow, busy);
        end
      end
      @(negedge clk);
    end
    start_check = 1'b0;
    outReady = 1'b1;
    for (int c = 0; c < 120 && (c < 40 || q.size() > 0); c++) begin
      start_check = (c == 40);
      if (c == 40) begin psumArr = mk_ramp(900); push_case(psumArr); end
      if (outValid) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL ovf_extra: got word d=%0d c=%0d, want none", outData, outCase);
        end else begin
          e = q.pop_front();
          checks++;
          if ({outData, outIdx, outCase, outLast} !== {e.data, e.idx, e.cs, e.last}) begin
            failures++;
            $display("FAIL ovf_word: got d=%0d i=%0d c=%0d l=%b, want d=%0d i=%0d c=%0d l=%b",
                     outData, outIdx, outCase, outLast, e.data, e.idx, e.cs, e.last);
          end
        end
      end
      @(negedge clk);
    end
    start_check = 1'b0;
    checks++;
    if (overflow !== 1'b1 || q.size() != 0) begin
      failures++;
      $display("FAIL ovf_end: got overflow=%b left=%0d, want 1 0", overflow, q.size());
    end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    logic hit;
    hit = 1'b0;
    outReady = 1'b1;
    psumArr = mk_ramp(400); start_check = 1'b1;
    @(negedge clk);
    start_check = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      if (outValid && outIdx == IW'(7)) hit = 1'b1;
      else @(negedge clk);
    end
    rstSys = 1'b1;
    @(negedge clk);
    rstSys = 1'b0;
    checks++;
    if (!hit || outValid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid: got hit=%b valid=%b busy=%b ovf=%b, want 1 0 0 0", hit, outValid, busy, overflow);
    end
    q.delete();
    exp_case = '0;
    psumArr = mk_ramp(500); start_check = 1'b1;
    push_case(psumArr);
    @(negedge clk);
    start_check = 1'b0;
    for (int c = 0; c < 40 && q.size() > 0; c++) begin
      if (outValid) begin
        e = q.pop_front();
        checks++;
        if ({outData, outIdx, outCase, outLast} !== {e.data, e.idx, e.cs, e.last}) begin
          failures++;
          $display("FAIL rst_word: got d=%0d i=%0d c=%0d l=%b, want d=%0d i=%0d c=%0d l=%b",
                   outData, outIdx, outCase, outLast, e.data, e.idx, e.cs, e.last);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (q.size() != 0 || outValid !== 1'b0) begin
      failures++;
      $display("FAIL rst_end: got left=%0d valid=%b, want 0 0", q.size(), outValid);
    end
  endtask

  initial begin
    rstSys = 1'b1; start_check = 1'b0; outReady = 1'b0; psumArr = '0;
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_simultaneous();
    test_overflow();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/result_drain.md
RESULT_DRAIN -- requirements
Module: result_drain

Interface
REQ-001 Parameter N, default 4, PE array dimension (array is N x N).
REQ-002 Parameter DATA_W, default 16, width of one PE accumulator result.
REQ-003 Parameter CASE_W, default 8, width of the test-case counter.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rstSys  input  1  reset, synchronous, active-high.
REQ-006 start_check  input  1  capture strobe from the array controller; high for one cycle when results are final.
REQ-007 psumArr  input  N*N*DATA_W  packed PE results; element k at bits [k*DATA_W +: DATA_W], k=0 top-left, k=N*N-1 bottom-right, row-major.
REQ-008 outValid  output  1  result word valid.
REQ-009 outReady  input  1  downstream accepts word.
REQ-010 outData  output  DATA_W  current result element.
REQ-011 outIdx  output  log2(N*N)  row-major index of outData.
REQ-012 outLast  output  1  high with the final element (idx N*N-1) of a case.
REQ-013 outCase  output  CASE_W  test-case number of the word being presented.
REQ-014 overflow  output  1  sticky; a capture was dropped.
REQ-015 busy  output  1  high when either buffer slot is occupied.

Function
REQ-016 The block SHALL hold two result slots (ping-pong); each slot stores the full psumArr plus its case tag.
REQ-017 On a cycle with start_check high and a free slot, the block SHALL write psumArr and the current case count into the write slot at that clock edge.
REQ-018 A slot released by the reader in the same cycle SHALL count as free for a simultaneous capture.
REQ-019 With start_check high and both slots occupied (no simultaneous release), the capture SHALL be dropped and overflow set to 1.
REQ-020 The case counter SHALL increment on every start_check, captured or dropped, wrapping 2^CASE_W-1 -> 0, so dropped cases appear as gaps in outCase.
REQ-021 The reader FSM SHALL have states IDLE (outValid=0) and DRAIN (outValid=1).
REQ-022 IDLE -> DRAIN on the edge after any slot becomes occupied; a capture at edge t gives outValid=1 in cycle t+1 with outIdx=0.
REQ-023 In DRAIN, outData/outIdx/outCase/outLast SHALL remain stable while outValid=1 and outReady=0.
REQ-024 On outValid && outReady, outIdx SHALL advance by 1; on the transfer with outIdx=N*N-1 (outLast=1), the read slot SHALL be released and the read pointer toggled.
REQ-025 After a last-word transfer, if the other slot is occupied, the FSM SHALL stay in DRAIN with outIdx=0 of the next case in the following cycle (no bubble); otherwise it SHALL go to IDLE.
REQ-026 Cases SHALL be emitted in capture order; words within a case in ascending outIdx.
REQ-027 Minimum drain time per case SHALL be N*N cycles with outReady held high.
REQ-028 busy SHALL equal (slot0 occupied OR slot1 occupied).

Reset
REQ-029 While rstSys=1 at a clock edge, the block SHALL clear both slot-occupied flags, read/write pointers, outIdx and case counter to 0, overflow to 0, and FSM to IDLE.
REQ-030 After reset, outValid=0, outLast=0, busy=0; outData and outCase SHALL be 0.
REQ-031 Reset asserted mid-drain SHALL abandon the in-flight case without completing it; no word is presented in the cycle after reset.
REQ-032 start_check coincident with rstSys SHALL be ignored (no capture, no count).

Structure
REQ-033 A shared package SHALL hold N, DATA_W, CASE_W defaults, derived IDX_W = log2(N*N), and the reader state enum {IDLE, DRAIN}.
REQ-034 Slot storage and occupancy flags SHALL be a sub-module result_buf (two entries, write port, read port with element select); FSM, counters and handshake stay in result_drain.

Verification
REQ-035 Single case: psumArr element k = k+100, start_check one cycle, outReady=1 -> 16 words 100..115, outIdx 0..15, outCase=0, outLast only on idx 15, outValid first high the cycle after start_check.
REQ-036 Backpressure: outReady toggled 1,0,0,1 repeating -> no word lost or duplicated, outData stable on every stall cycle.
REQ-037 Back-to-back: two start_check 3 cycles apart with values A and B, outReady=1 -> 32 contiguous valid cycles, case 0 then case 1, no bubble at the boundary.
REQ-038 Overflow: outReady=0, three start_check pulses -> third dropped, overflow=1 and stays 1; after releasing outReady, cases 0 and 1 emitted, next capture tagged 3.
REQ-039 Simultaneous: both slots full, start_check in the same cycle as the last-word transfer -> captured, overflow stays 0.
REQ-040 Reset mid-drain at outIdx=7 -> next cycle outValid=0, busy=0, overflow=0; next capture emits outCase=0 from outIdx=0.
